// File: rtl/us_cmd_arbiter_pkg.sv
// Shared definitions for the upstream command arbiter: command type codes and field offsets.
// The optional completion-priority mode is selected with US_CMD_ARB_CPL_PRIO_EN.
package us_cmd_arbiter_pkg;

  localparam int US_CMD_DW = 128;

  localparam logic [1:0] US_CMD_INVALID_TYPE = 2'b00;
  localparam logic [1:0] US_CMD_CPL_TYPE     = 2'b01;
  localparam logic [1:0] US_CMD_CPLD_TYPE    = 2'b10;
  localparam logic [1:0] US_CMD_WR32_TYPE    = 2'b11;

  localparam int US_CMD_ID_LSB   = 55;
  localparam int US_CMD_ID_W     = 2;
  localparam int US_CMD_LEN_LSB  = 57;
  localparam int US_CMD_LEN_W    = 5;
  localparam int US_CMD_TYPE_LSB = 62;
  localparam int US_CMD_TYPE_W   = 2;

  function automatic logic is_cpl_type(input logic [US_CMD_TYPE_W-1:0] t);
    return (t == US_CMD_CPL_TYPE) || (t == US_CMD_CPLD_TYPE);
  endfunction

endpackage

// File: rtl/us_cmd_arbiter_if.sv
// Requester, FIFO-write and debug-readback bundle of the upstream command arbiter.
interface us_cmd_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DW    = 128,
  parameter int CNT_W = 16
);
  logic [NREQ-1:0]    req_i;
  logic [NREQ*DW-1:0] cmd_i;
  logic [NREQ-1:0]    gnt_o;
  logic               us_cmd_fifo_full_i;
  logic               us_cmd_fifo_prog_full_i;
  logic [DW-1:0]      us_cmd_fifo_din_o;
  logic               us_cmd_fifo_wr_en_o;
  logic [2:0]         cnt_sel_i;
  logic [CNT_W-1:0]   cnt_o;
  logic               busy_o;

  modport master (
    output req_i, cmd_i, us_cmd_fifo_full_i, us_cmd_fifo_prog_full_i, cnt_sel_i,
    input  gnt_o, us_cmd_fifo_din_o, us_cmd_fifo_wr_en_o, cnt_o, busy_o
  );

  modport slave (
    input  req_i, cmd_i, us_cmd_fifo_full_i, us_cmd_fifo_prog_full_i, cnt_sel_i,
    output gnt_o, us_cmd_fifo_din_o, us_cmd_fifo_wr_en_o, cnt_o, busy_o
  );
endinterface

// File: rtl/us_cmd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NREQ.
module us_cmd_arbiter_rr_pick #(
  parameter  int NREQ = 4,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx,
  output logic            any
);
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    // Walk offsets from farthest to nearest so the nearest hit is the one left standing.
    for (int i = NREQ - 1; i >= 0; i--) begin
      int pos;
      pos = int'(ptr) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      if (req[pos]) begin
        onehot      = '0;
        onehot[pos] = 1'b1;
        idx         = PW'(pos);
        any         = 1'b1;
      end
    end
  end
endmodule

// File: rtl/us_cmd_arbiter.sv
// Round-robin arbiter sharing the upstream command FIFO, with a one-entry output stage
// and saturating per-requester grant counters. Define US_CMD_ARB_CPL_PRIO_EN for completion priority.
module us_cmd_arbiter
  import us_cmd_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = US_CMD_DW,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  us_cmd_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              out_vld_reg;
  logic [DW-1:0]     out_q_reg;
  logic [PW-1:0]     ptr_reg;
  logic [NREQ*CNT_W-1:0] cnt_all;

  logic              wr_en;
  logic              grant_ok;
  logic              grant_fire;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   win_onehot;
  logic [PW-1:0]     win_idx;
  logic              win_any;
  logic              win_moves_ptr;

  logic [NREQ-1:0]   rr_onehot;
  logic [PW-1:0]     rr_idx;
  logic              rr_any;

`ifdef US_CMD_ARB_CPL_PRIO_EN
  logic [NREQ-1:0]   cpl_req;
  logic [NREQ-1:0]   cpl_onehot;
  logic [PW-1:0]     cpl_idx;
  logic              cpl_any;

  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_cpl
    assign cpl_req[gi] = bus.req_i[gi] &
                         is_cpl_type(bus.cmd_i[gi*DW + US_CMD_TYPE_LSB +: US_CMD_TYPE_W]);
  end

  // Completions use fixed lowest-index priority so a DMA flood can never starve them.
  us_cmd_arbiter_rr_pick #(.NREQ(NREQ)) u_cpl_pick (
    .req    (cpl_req),
    .ptr    ('0),
    .onehot (cpl_onehot),
    .idx    (cpl_idx),
    .any    (cpl_any)
  );

  us_cmd_arbiter_rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req    (bus.req_i & ~cpl_req),
    .ptr    (ptr_reg),
    .onehot (rr_onehot),
    .idx    (rr_idx),
    .any    (rr_any)
  );

  assign win_onehot    = cpl_any ? cpl_onehot : rr_onehot;
  assign win_idx       = cpl_any ? cpl_idx    : rr_idx;
  assign win_any       = cpl_any | rr_any;
  assign win_moves_ptr = ~cpl_any;
`else
  genvar gi;

  us_cmd_arbiter_rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req    (bus.req_i),
    .ptr    (ptr_reg),
    .onehot (rr_onehot),
    .idx    (rr_idx),
    .any    (rr_any)
  );

  assign win_onehot    = rr_onehot;
  assign win_idx       = rr_idx;
  assign win_any       = rr_any;
  assign win_moves_ptr = 1'b1;
`endif

  // A new grant is allowed only when the stage is empty or drains this same cycle.
  assign wr_en      = ~rst & out_vld_reg & ~bus.us_cmd_fifo_full_i;
  assign grant_ok   = ~rst & ~bus.us_cmd_fifo_prog_full_i & (~out_vld_reg | wr_en);
  assign grant_fire = grant_ok & win_any;
  assign gnt        = grant_ok ? win_onehot : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_reg <= 1'b0;
      out_q_reg   <= '0;
      ptr_reg     <= '0;
    end else if (grant_fire) begin
      out_vld_reg <= 1'b1;
      out_q_reg   <= bus.cmd_i[int'(win_idx)*DW +: DW];
      if (win_moves_ptr)
        ptr_reg <= (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
    end else if (wr_en) begin
      out_vld_reg <= 1'b0;
    end
  end

  for (gi = 0; gi < NREQ; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (rst)
        cnt_reg <= '0;
      else if (gnt[gi] && cnt_reg != CNT_MAX)
        cnt_reg <= cnt_reg + 1'b1;
    end
    assign cnt_all[gi*CNT_W +: CNT_W] = cnt_reg;
  end

  always_comb begin
    bus.cnt_o = '0;
    if (int'(bus.cnt_sel_i) < NREQ)
      bus.cnt_o = cnt_all[int'(bus.cnt_sel_i)*CNT_W +: CNT_W];
  end

  assign bus.gnt_o               = gnt;
  assign bus.us_cmd_fifo_wr_en_o = wr_en;
  assign bus.us_cmd_fifo_din_o   = out_q_reg;
  assign bus.busy_o              = out_vld_reg;
endmodule

// File: tb/tb_us_cmd_arbiter.sv
// Randomized bench for us_cmd_arbiter against a cycle-level behavioural model of the sharing rules.
module tb_us_cmd_arbiter;
  import us_cmd_arbiter_pkg::*;

  localparam int NREQ  = 4;
  localparam int DW    = 128;
  localparam int CNT_W = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  us_cmd_arbiter_if #(.NREQ(NREQ), .DW(DW), .CNT_W(CNT_W)) bus();

  us_cmd_arbiter #(.NREQ(NREQ), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // requester agents
  bit            pend [NREQ];
  logic [DW-1:0] pcmd [NREQ];
  logic [NREQ-1:0] req_mask = '0;
  int  req_rate = 0, drop_rate = 0, sel_force = -1;
  bit  full_drv = 0, pfull_drv = 0;

  // reference model state
  bit            m_vld = 0;
  logic [DW-1:0] m_q = '0;
  int            m_ptr = 0;
  int            m_cnt [NREQ];

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_cmd();
    logic [DW-1:0] c;
    for (int w = 0; w < DW / 32; w++) c[w*32 +: 32] = $urandom;
    return c;
  endfunction

  function automatic bit cpl_prio(input logic [1:0] t);
    bit c;
    c = (t == US_CMD_CPL_TYPE) || (t == US_CMD_CPLD_TYPE);
`ifdef US_CMD_ARB_CPL_PRIO_EN
    return c;
`else
    return 1'b0 && c;
`endif
  endfunction

  task automatic tick(input bit do_rst = 1'b0);
    int win, sel;
    bit win_cpl, exp_wr, can;
    logic [NREQ-1:0] exp_gnt;
    logic [CNT_W-1:0] exp_cnt;

    for (int k = 0; k < NREQ; k++) begin
      if (!pend[k]) begin
        if (req_mask[k] && $urandom_range(99) < req_rate) begin
          pend[k] = 1'b1;
          pcmd[k] = rand_cmd();
        end
      end else if ($urandom_range(99) < drop_rate) begin
        pend[k] = 1'b0;
      end
    end
    rst = do_rst;
    for (int k = 0; k < NREQ; k++) begin
      bus.req_i[k] = pend[k];
      bus.cmd_i[k*DW +: DW] = pcmd[k];
    end
    bus.us_cmd_fifo_full_i      = full_drv;
    bus.us_cmd_fifo_prog_full_i = pfull_drv;
    sel = (sel_force >= 0) ? sel_force : $urandom_range(7);
    bus.cnt_sel_i = 3'(sel);

    @(negedge clk);
    exp_wr = m_vld && !full_drv && !do_rst;
    can    = !do_rst && !pfull_drv && (!m_vld || exp_wr);
    win = -1;
    win_cpl = 1'b0;
    if (can) begin
      for (int k = 0; k < NREQ; k++)
        if (win < 0 && pend[k] && cpl_prio(pcmd[k][63:62])) begin
          win = k;
          win_cpl = 1'b1;
        end
      for (int i = 0; i < NREQ; i++) begin
        int k;
        k = (m_ptr + i) % NREQ;
        if (win < 0 && pend[k] && !cpl_prio(pcmd[k][63:62])) win = k;
      end
    end
    exp_gnt = (win >= 0) ? NREQ'(1 << win) : '0;
    exp_cnt = (sel < NREQ) ? CNT_W'(m_cnt[sel]) : '0;

    check_val("gnt",   DW'(bus.gnt_o), DW'(exp_gnt));
    check_val("wr_en", DW'(bus.us_cmd_fifo_wr_en_o), DW'(exp_wr));
    check_val("busy",  DW'(bus.busy_o), DW'(m_vld));
    check_val("din",   bus.us_cmd_fifo_din_o, m_q);
    check_val("cnt",   DW'(bus.cnt_o), DW'(exp_cnt));
    if (exp_wr) $display("write din=%h", m_q);

    if (do_rst) begin
      m_vld = 0;
      m_q   = '0;
      m_ptr = 0;
      for (int k = 0; k < NREQ; k++) m_cnt[k] = 0;
    end else if (win >= 0) begin
      m_q   = pcmd[win];
      m_vld = 1;
      if (!win_cpl) m_ptr = (win + 1) % NREQ;
      if (m_cnt[win] < CNT_SAT) m_cnt[win]++;
      pend[win] = 1'b0;
    end else if (exp_wr) begin
      m_vld = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      pend[k] = 1'b0;
      pcmd[k] = '0;
      m_cnt[k] = 0;
    end
    rst = 1'b1;
    bus.req_i = '0;
    bus.cmd_i = '0;
    bus.us_cmd_fifo_full_i = 1'b0;
    bus.us_cmd_fifo_prog_full_i = 1'b0;
    bus.cnt_sel_i = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset state, then all four requesting continuously
    repeat (2) tick();
    req_mask = '1; req_rate = 100; drop_rate = 0;
    repeat (10) tick();
    req_mask = '0;
    repeat (3) tick();

    // single requester held off by full, no regrant under prog_full
    req_mask = 4'b0100;
    tick();
    full_drv = 1; pfull_drv = 1;
    repeat (5) tick();
    full_drv = 0;
    repeat (2) tick();
    pfull_drv = 0;
    tick();
    req_mask = '0;
    repeat (3) tick();

    // prog_full blocks grants until it drops
    pfull_drv = 1; req_mask = 4'b0011;
    repeat (4) tick();
    pfull_drv = 0;
    tick();
    req_mask = '0;
    repeat (3) tick();

    // request withdrawn while blocked leaves nothing behind
    tick(1'b1);
    sel_force = 1; pfull_drv = 1; req_mask = 4'b0010;
    repeat (2) tick();
    pend[1] = 1'b0; req_mask = '0;
    tick();
    pfull_drv = 0;
    repeat (2) tick();

    // completion versus write ordering from pointer 0
    tick(1'b1);
    sel_force = 3; req_rate = 0;
    pend[0] = 1'b1; pcmd[0] = rand_cmd(); pcmd[0][63:62] = US_CMD_WR32_TYPE;
    pend[3] = 1'b1; pcmd[3] = rand_cmd(); pcmd[3][63:62] = US_CMD_CPLD_TYPE;
    repeat (4) tick();

    // reset while an entry is held against full, then counter saturation
    sel_force = 0; req_rate = 100; req_mask = 4'b0001; full_drv = 1;
    repeat (2) tick();
    tick(1'b1);
    full_drv = 0; req_mask = '0;
    repeat (2) tick();
    req_mask = 4'b0001;
    repeat (22) tick();
    req_mask = '0;
    repeat (2) tick();

    // randomized traffic
    sel_force = -1;
    for (int n = 0; n < 600; n++) begin
      req_mask  = NREQ'($urandom);
      req_rate  = $urandom_range(90, 20);
      drop_rate = 5;
      full_drv  = ($urandom_range(3) == 0);
      pfull_drv = ($urandom_range(2) == 0);
      tick($urandom_range(99) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
